// File: rtl/xdma_stream_arb_pkg.sv
// xdma_stream_arb_pkg: shared states, arbitration modes and slot helper for the XDMA stream burst arbiter
package xdma_stream_arb_pkg;

    typedef enum logic {IDLE, LOCK} arb_state_e;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    // k-th candidate slot after ptr, wrapping modulo n
    function automatic int unsigned rr_slot(input int unsigned ptr, input int unsigned k, input int unsigned n);
        return (ptr + 1 + k) % n;
    endfunction

endpackage

// File: rtl/xdma_rr_pick.sv
// xdma_rr_pick: combinational rotate-priority / fixed-priority picker returning one-hot grant and index
module xdma_rr_pick
    import xdma_stream_arb_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] c;

    // scan candidates from the slot after ptr (round-robin) or from slot 0 (fixed); first valid wins
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            c = IDX_W'((mode == ARB_RR) ? rr_slot(32'(ptr), k, N) : k);
            if (!found && valid[c]) begin
                found  = 1'b1;
                idx    = c;
                gnt[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xdma_stream_burst_arbiter.sv
// xdma_stream_burst_arbiter: N-to-1 valid/ready arbiter with per-source burst lock, registered output and session tracking
module xdma_stream_burst_arbiter
    import xdma_stream_arb_pkg::*;
#(
    parameter int unsigned N_INP      = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_W    = 8,
    parameter int unsigned IDX_W      = $clog2(N_INP)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          cfg_prio_mode_i,
    input  logic [N_INP*BURST_W-1:0]      cfg_burst_len_i,
    input  logic [N_INP-1:0]              inp_valid_i,
    output logic [N_INP-1:0]              inp_ready_o,
    input  logic [N_INP*DATA_WIDTH-1:0]   inp_data_i,
    input  logic [N_INP-1:0]              inp_last_i,
    output logic                          oup_valid_o,
    input  logic                          oup_ready_i,
    output logic [DATA_WIDTH-1:0]         oup_data_o,
    output logic [IDX_W-1:0]              oup_idx_o,
    output logic                          oup_last_o,
    output logic                          start_o,
    output logic                          busy_o,
    input  logic                          done_i
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [IDX_W-1:0]      idx;
        logic                  last;
    } out_beat_t;

    arb_state_e            state, state_nx;
    logic [IDX_W-1:0]      g, rr_ptr, pick_idx;
    logic [N_INP-1:0]      pick_gnt;
    logic [BURST_W-1:0]    cnt;
    out_beat_t             oup_q;
    logic                  out_reg_free, accept, rel_flag, grant;
    logic [DATA_WIDTH-1:0] inp_data  [N_INP];
    logic [BURST_W-1:0]    burst_len [N_INP];

    for (genvar i = 0; i < N_INP; i++) begin : g_unpack
        assign inp_data[i]  = inp_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        assign burst_len[i] = cfg_burst_len_i[i*BURST_W +: BURST_W];
    end

    xdma_rr_pick #(.N(N_INP), .IDX_W(IDX_W)) u_pick (
        .valid (inp_valid_i),
        .ptr   (rr_ptr),
        .mode  (cfg_prio_mode_i),
        .gnt   (pick_gnt),
        .idx   (pick_idx)
    );

    assign out_reg_free = !oup_valid_o || oup_ready_i;
    assign start_o      = accept && !busy_o;
    assign oup_data_o   = oup_q.data;
    assign oup_idx_o    = oup_q.idx;
    assign oup_last_o   = oup_q.last;

    // state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nx;
    end

    // arbitrate in IDLE; in LOCK open only the locked channel and decide on release
    always_comb begin
        state_nx    = state;
        inp_ready_o = '0;
        accept      = 1'b0;
        rel_flag    = 1'b0;
        grant       = 1'b0;
        if (state == IDLE) begin
            grant    = |pick_gnt;
            state_nx = grant ? LOCK : IDLE;
        end else begin
            inp_ready_o[g] = out_reg_free;
            accept         = inp_valid_i[g] && out_reg_free;
            rel_flag       = inp_last_i[g] || cnt == BURST_W'(1) || done_i;
            state_nx       = (done_i || (accept && rel_flag)) ? IDLE : LOCK;
        end
    end

    // latch winner, pointer and burst length at grant; count down accepted beats (0 means unbounded)
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            g      <= '0;
            rr_ptr <= IDX_W'(N_INP - 1);
            cnt    <= '0;
        end else if (grant) begin
            g      <= pick_idx;
            rr_ptr <= pick_idx;
            cnt    <= burst_len[pick_idx];
        end else if (accept && cnt != '0) begin
            cnt <= cnt - BURST_W'(1);
        end
    end

    // single-entry output register: load on accept, clear on pop, hold while stalled
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            oup_valid_o <= 1'b0;
            oup_q       <= '0;
        end else if (accept) begin
            oup_valid_o <= 1'b1;
            oup_q       <= '{data: inp_data[g], idx: g, last: rel_flag};
        end else if (oup_ready_i) begin
            oup_valid_o <= 1'b0;
        end
    end

    // session flag: set by the first accepted beat, cleared by done
    always_ff @(posedge clk_i) begin
        if (!rst_ni)     busy_o <= 1'b0;
        else if (done_i) busy_o <= 1'b0;
        else if (accept) busy_o <= 1'b1;
    end

endmodule

// File: tb/tb_xdma_stream_burst_arbiter.sv
// tb_xdma_stream_burst_arbiter: directed stimulus with per-channel source queues and a scoreboard monitor
module tb_xdma_stream_burst_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int BW = 8;
    localparam int IW = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            cfg_prio_mode_i = 1'b0;
    logic [N*BW-1:0] cfg_burst_len_i = '0;
    logic [N-1:0]    inp_valid_i = '0;
    logic [N-1:0]    inp_ready_o;
    logic [N*DW-1:0] inp_data_i = '0;
    logic [N-1:0]    inp_last_i = '0;
    logic            oup_valid_o;
    logic            oup_ready_i = 1'b1;
    logic [DW-1:0]   oup_data_o;
    logic [IW-1:0]   oup_idx_o;
    logic            oup_last_o;
    logic            start_o;
    logic            busy_o;
    logic            done_i = 1'b0;

    typedef struct packed {logic [DW-1:0] data; logic last;} src_t;
    typedef struct packed {logic [DW-1:0] data; logic [IW-1:0] idx; logic last;} exp_t;

    src_t         src_q[N][$];
    exp_t         exp_q[$];
    logic [N-1:0] en = '0;
    bit           mon_en = 1'b1;
    bit           rand_rdy = 1'b0;
    int           checks = 0;
    int           failures = 0;

    xdma_stream_burst_arbiter #(.N_INP(N), .DATA_WIDTH(DW), .BURST_W(BW)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .cfg_prio_mode_i (cfg_prio_mode_i),
        .cfg_burst_len_i (cfg_burst_len_i),
        .inp_valid_i     (inp_valid_i),
        .inp_ready_o     (inp_ready_o),
        .inp_data_i      (inp_data_i),
        .inp_last_i      (inp_last_i),
        .oup_valid_o     (oup_valid_o),
        .oup_ready_i     (oup_ready_i),
        .oup_data_o      (oup_data_o),
        .oup_idx_o       (oup_idx_o),
        .oup_last_o      (oup_last_o),
        .start_o         (start_o),
        .busy_o          (busy_o),
        .done_i          (done_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] dv(int t, int ch, int n);
        return {8'hA0 + 8'(t), 8'(ch), 16'(n)};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic exp_beat(int t, int ch, int n, bit last);
        exp_q.push_back('{data: dv(t, ch, n), idx: IW'(ch), last: last});
    endtask

    task automatic push1(int t, int ch, int n, bit last);
        src_q[ch].push_back('{data: dv(t, ch, n), last: last});
    endtask

    task automatic send(int t, int ch, int cnt, bit last_end);
        for (int n = 0; n < cnt; n++) push1(t, ch, n, last_end && n == cnt - 1);
    endtask

    task automatic drain(string name);
        int k = 0;
        while ((src_q[0].size() + src_q[1].size() + src_q[2].size() != 0 || exp_q.size() != 0 || oup_valid_o) && k < 1000) begin
            @(negedge clk_i);
            k++;
        end
        check({name, "_drain_in_time"}, 64'(k < 1000), 64'd1);
        check({name, "_no_missing_beats"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        en     = '0;
        mon_en = 1'b0;
        for (int c = 0; c < N; c++) src_q[c].delete();
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        mon_en = 1'b1;
    endtask

    // source driver: retire handshaken beats, present queue heads, drive output ready
    initial begin
        logic [N-1:0] fire;
        forever begin
            @(negedge clk_i);
            fire = inp_valid_i & inp_ready_o;
            @(posedge clk_i);
            #1;
            for (int c = 0; c < N; c++) begin
                if (fire[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
                inp_valid_i[c]         = en[c] && src_q[c].size() > 0;
                inp_data_i[c*DW +: DW] = src_q[c].size() > 0 ? src_q[c][0].data : '0;
                inp_last_i[c]          = src_q[c].size() > 0 ? src_q[c][0].last : 1'b0;
            end
            oup_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // scoreboard monitor: every output handshake is compared with the next expected beat
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (mon_en && oup_valid_o && oup_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_unexpected actual data=%h idx=%0d last=%0d required=none", oup_data_o, oup_idx_o, oup_last_o);
                end else begin
                    e = exp_q.pop_front();
                    check("beat{data,idx,last}", 64'({oup_data_o, oup_idx_o, oup_last_o}), 64'(e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(negedge clk_i);
        check("rst_oup_valid", 64'(oup_valid_o), 64'd0);
        check("rst_oup_data", 64'(oup_data_o), 64'd0);
        check("rst_oup_idx", 64'(oup_idx_o), 64'd0);
        check("rst_oup_last", 64'(oup_last_o), 64'd0);
        check("rst_start", 64'(start_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_inp_ready", 64'(inp_ready_o), 64'd0);
        rst_ni = 1'b1;

        cfg_burst_len_i = {8'd1, 8'd1, 8'd1};
        for (int n = 0; n < 2; n++)
            for (int c = 0; c < N; c++) exp_beat(1, c, n, 1'b1);
        for (int c = 0; c < N; c++) send(1, c, 2, 1'b0);
        en = '1;
        drain("rr_single");

        cfg_burst_len_i = {8'd1, 8'd4, 8'd1};
        exp_beat(2, 1, 0, 1'b0);
        exp_beat(2, 1, 1, 1'b0);
        exp_beat(2, 1, 2, 1'b0);
        exp_beat(2, 1, 3, 1'b1);
        exp_beat(2, 2, 0, 1'b1);
        exp_beat(2, 2, 1, 1'b1);
        send(2, 1, 4, 1'b0);
        send(2, 2, 2, 1'b0);
        drain("burst_lock");

        cfg_burst_len_i = {8'd1, 8'd1, 8'd0};
        for (int n = 0; n < 6; n++) exp_beat(3, 0, n, n == 5);
        send(3, 0, 6, 1'b1);
        drain("last_unbounded");

        cfg_burst_len_i = {8'd1, 8'd1, 8'd5};
        exp_beat(4, 1, 0, 1'b1);
        exp_beat(4, 0, 0, 1'b0);
        exp_beat(4, 0, 1, 1'b1);
        exp_beat(4, 1, 1, 1'b1);
        exp_beat(4, 0, 2, 1'b1);
        push1(4, 0, 0, 1'b0);
        push1(4, 0, 1, 1'b1);
        push1(4, 0, 2, 1'b1);
        push1(4, 1, 0, 1'b0);
        push1(4, 1, 1, 1'b0);
        drain("last_over_count");

        cfg_prio_mode_i = 1'b1;
        cfg_burst_len_i = {8'd2, 8'd2, 8'd2};
        for (int n = 0; n < 4; n++) exp_beat(5, 0, n, n[0]);
        for (int c = 1; c < N; c++) begin
            exp_beat(5, c, 0, 1'b0);
            exp_beat(5, c, 1, 1'b1);
        end
        send(5, 0, 4, 1'b0);
        send(5, 1, 2, 1'b0);
        send(5, 2, 2, 1'b0);
        drain("fixed_prio");
        cfg_prio_mode_i = 1'b0;

        do_reset();
        cfg_burst_len_i = {8'd3, 8'd3, 8'd3};
        for (int c = 0; c < N; c++) begin
            exp_beat(6, c, 0, 1'b0);
            exp_beat(6, c, 1, 1'b0);
            exp_beat(6, c, 2, 1'b1);
        end
        for (int c = 0; c < N; c++) exp_beat(6, c, 3, 1'b1);
        for (int c = 0; c < N; c++) send(6, c, 4, 1'b1);
        rand_rdy = 1'b1;
        en = '1;
        drain("backpressure");
        rand_rdy = 1'b0;

        do_reset();
        cfg_burst_len_i = {8'd4, 8'd4, 8'd4};
        exp_beat(7, 0, 0, 1'b0);
        exp_beat(7, 0, 1, 1'b1);
        send(7, 0, 4, 1'b0);
        en = '1;
        k = 0;
        while (!start_o && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        check("start_seen", 64'(k < 20), 64'd1);
        check("busy_low_at_start", 64'(busy_o), 64'd0);
        @(negedge clk_i);
        check("start_one_cycle", 64'(start_o), 64'd0);
        check("busy_rise", 64'(busy_o), 64'd1);
        done_i = 1'b1;
        en[0]  = 1'b0;
        @(posedge clk_i);
        #1 done_i = 1'b0;
        @(negedge clk_i);
        check("busy_after_done", 64'(busy_o), 64'd0);
        check("ready_after_done", 64'(inp_ready_o), 64'd0);
        src_q[0].delete();
        drain("session_done");

        mon_en = 1'b0;
        exp_q.delete();
        send(8, 0, 4, 1'b0);
        en = '1;
        k = 0;
        while (!oup_valid_o && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        check("valid_before_reset", 64'(oup_valid_o), 64'd1);
        rst_ni = 1'b0;
        en     = '0;
        @(negedge clk_i);
        check("midburst_rst_valid", 64'(oup_valid_o), 64'd0);
        check("midburst_rst_busy", 64'(busy_o), 64'd0);
        check("midburst_rst_ready", 64'(inp_ready_o), 64'd0);
        check("midburst_rst_last", 64'(oup_last_o), 64'd0);
        for (int c = 0; c < N; c++) src_q[c].delete();
        rst_ni = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
